// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider: output mode encodings
// and the default counter width and divisor.
package clk_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int DEF_CNT_W   = 28;
  localparam int DEF_DIV_VAL = 50000000;

endpackage

// File: rtl/clk_div_prog.sv
// Programmable clock divider with a shadowed divisor that is applied at terminal
// count, plus square-wave or single-cycle pulse output modes.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             mode,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             load_pend
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             load_pend_q, load_pend_d;

  logic             act_zero;
  logic             tc;
  logic [CNT_W-1:0] new_div;

  assign act_zero = (act_q == '0);
  assign tc       = en && !act_zero && (cnt_q == act_q - CNT_W'(1));
  // A same-cycle load beats whatever is waiting in the shadow register.
  assign new_div  = div_load ? div_val : shd_q;

  always_comb begin
    cnt_d       = cnt_q;
    act_d       = act_q;
    shd_d       = shd_q;
    clk_out_d   = clk_out_q;
    tick_d      = 1'b0;
    load_pend_d = load_pend_q;

    if (div_load) begin
      shd_d       = div_val;
      load_pend_d = 1'b1;
    end

    if (sync_clr) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      if (div_load || load_pend_q) begin
        act_d       = new_div;
        load_pend_d = 1'b0;
      end
    end else if (tc) begin
      cnt_d     = '0;
      tick_d    = 1'b1;
      clk_out_d = (mode == MODE_PULSE) ? 1'b1 : ~clk_out_q;
      if (div_load || load_pend_q) begin
        act_d       = new_div;
        load_pend_d = 1'b0;
      end
    end else if (act_zero) begin
      // Stopped divider: the waiting divisor goes live on this edge; a fresh
      // load arriving now stays pending for the following edge.
      if (load_pend_q) begin
        act_d       = shd_q;
        load_pend_d = div_load;
        cnt_d       = (cnt_q >= shd_q) ? '0 : cnt_q;
      end
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (mode == MODE_PULSE) clk_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      act_q       <= CNT_W'(DEF_DIV);
      shd_q       <= CNT_W'(DEF_DIV);
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      shd_q       <= shd_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign load_pend = load_pend_q;

endmodule
